dcpu16_xalu: RTL



---
 rtl/dcpu16_pkg.sv | 28 ++
 rtl/dcpu16_div.sv | 89 ++++++++
 rtl/dcpu16_xalu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 execute-stage ALU.
// Provides the opcode map and the handshake FSM state encoding.
package dcpu16_pkg;

  localparam logic [3:0] OP_JSR = 4'h0;
  localparam logic [3:0] OP_SET = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_MOD = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_BOR = 4'hA;
  localparam logic [3:0] OP_XOR = 4'hB;
  localparam logic [3:0] OP_IFE = 4'hC;
  localparam logic [3:0] OP_IFN = 4'hD;
  localparam logic [3:0] OP_IFG = 4'hE;
  localparam logic [3:0] OP_IFB = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } xalu_state_t;

endpackage

// File: rtl/dcpu16_div.sv
// Restoring shift-subtract divider, one quotient bit per enabled cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ena           global stall; all state holds when low
//   i_start       load operands; the first iteration happens on this edge
//   i_dvd         dividend (2W bits, consumed MSB first)
//   i_dvs         divisor (W bits, nonzero)
//   i_cnt         number of iterations to run
//   o_done        one-cycle pulse: quotient/remainder are final
//   o_quo, o_rem  quotient (2W bits) and remainder (W bits)
module dcpu16_div #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           i_start,
  input  logic [2*W-1:0] i_dvd,
  input  logic [W-1:0]   i_dvs,
  input  logic [N-1:0]   i_cnt,
  output logic           o_done,
  output logic [2*W-1:0] o_quo,
  output logic [W-1:0]   o_rem
);

  localparam int unsigned W2 = 2 * W;

  logic [W2-1:0] r_dvd;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_rem;
  logic [W2-1:0] r_quo;
  logic [N-1:0]  r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [W2-1:0] w_dvd_src;
  logic [W-1:0]  w_dvs_src;
  logic [W-1:0]  w_rem_src;
  logic [W2-1:0] w_quo_src;
  logic [W:0]    w_r2;
  logic          w_ge;

  // On start the step works directly on the incoming operands, saving a cycle.
  assign w_dvd_src = i_start ? i_dvd : r_dvd;
  assign w_dvs_src = i_start ? i_dvs : r_dvs;
  assign w_rem_src = i_start ? '0    : r_rem;
  assign w_quo_src = i_start ? '0    : r_quo;

  // Partial remainder stays below the divisor, so W+1 bits suffice for the trial.
  assign w_r2 = {w_rem_src, w_dvd_src[W2-1]};
  assign w_ge = (w_r2 >= {1'b0, w_dvs_src});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (ena) begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_dvd <= W2'({w_dvd_src, 1'b0});
        r_dvs <= w_dvs_src;
        r_rem <= w_ge ? W'(w_r2 - {1'b0, w_dvs_src}) : W'(w_r2);
        r_quo <= W2'({w_quo_src, w_ge});
      end
      if (i_start) begin
        r_cnt  <= i_cnt - N'(1);
        r_busy <= (i_cnt != N'(1));
        r_done <= (i_cnt == N'(1));
      end else if (r_busy) begin
        r_cnt <= r_cnt - N'(1);
        if (r_cnt == N'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/dcpu16_xalu.sv
// DCPU16 execute-stage ALU with valid/ready operand handshake and iterative DIV/MOD.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ena                global stall
//   in_vld, in_rdy     operand handshake (accept = in_vld & in_rdy & ena)
//   opc, src, tgt      opcode and operands a/b
//   out_vld            one-cycle pulse when res/regO/CC update
//   res, regO, CC      result, overflow register, condition flag
module dcpu16_xalu
  import dcpu16_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned SHW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [3:0]   opc,
  input  logic [W-1:0] src,
  input  logic [W-1:0] tgt,
  output logic         out_vld,
  output logic [W-1:0] res,
  output logic [W-1:0] regO,
  output logic         CC
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = $clog2(W2) + 1;

  xalu_state_t r_state;
  logic         r_in_rdy;
  logic         r_out_vld;
  logic [W-1:0] r_res;
  logic [W-1:0] r_o;
  logic         r_cc;
  logic         r_is_mod;

  logic [W:0]     w_sum;
  logic [W:0]     w_dif;
  logic [W2-1:0]  w_prod;
  logic           w_sh_ovr;
  logic [SHW-1:0] w_sh_amt;
  logic [W2-1:0]  w_shl;
  logic [W2-1:0]  w_shr;
  logic [W-1:0]   w_res;
  logic [W-1:0]   w_o;
  logic           w_cc;
  logic           w_div_go;
  logic           w_div_start;
  logic [CW-1:0]  w_div_cnt;
  logic           w_div_done;
  logic [W2-1:0]  w_quo;
  logic [W-1:0]   w_rem;

  // Single-cycle arithmetic terms.
  assign w_sum    = {1'b0, src} + {1'b0, tgt};
  assign w_dif    = {1'b0, src} - {1'b0, tgt};
  assign w_prod   = W2'(src) * W2'(tgt);
  assign w_sh_ovr = (tgt >= W'(W2));
  assign w_sh_amt = tgt[SHW-1:0];
  assign w_shl    = w_sh_ovr ? '0 : (W2'(src) << w_sh_amt);
  assign w_shr    = w_sh_ovr ? '0 : ({src, {W{1'b0}}} >> w_sh_amt);

  // Next res/O/CC for every op that completes on the accept edge.
  always_comb begin
    w_res = r_res;
    w_o   = r_o;
    w_cc  = 1'b1;
    case (opc)
      OP_JSR: w_res = src;
      OP_SET: w_res = tgt;
      OP_ADD: begin w_res = w_sum[W-1:0]; w_o = W'(w_sum[W]); end
      OP_SUB: begin w_res = w_dif[W-1:0]; w_o = {W{w_dif[W]}}; end
      OP_MUL: {w_o, w_res} = w_prod;
      OP_DIV: begin w_res = '0; w_o = '0; end  // reached only for tgt == 0
      OP_MOD: w_res = '0;                      // reached only for tgt == 0
      OP_SHL: {w_o, w_res} = w_shl;
      OP_SHR: {w_res, w_o} = w_shr;
      OP_AND: w_res = src & tgt;
      OP_BOR: w_res = src | tgt;
      OP_XOR: w_res = src ^ tgt;
      OP_IFE: w_cc = (src == tgt);
      OP_IFN: w_cc = (src != tgt);
      OP_IFG: w_cc = (src > tgt);
      OP_IFB: w_cc = |(src & tgt);
      default: w_cc = 1'b1;
    endcase
  end

  assign w_div_go    = ((opc == OP_DIV) || (opc == OP_MOD)) && (tgt != '0);
  assign w_div_start = ena && in_vld && (r_state == ST_IDLE) && w_div_go;
  assign w_div_cnt   = (opc == OP_MOD) ? CW'(W) : CW'(W2);

  dcpu16_div #(
    .W (W),
    .N (CW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .i_start (w_div_start),
    .i_dvd   ({src, {W{1'b0}}}),
    .i_dvs   (tgt),
    .i_cnt   (w_div_cnt),
    .o_done  (w_div_done),
    .o_quo   (w_quo),
    .o_rem   (w_rem)
  );

  // Handshake FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_res     <= '0;
      r_o       <= '0;
      r_cc      <= 1'b0;
      r_is_mod  <= 1'b0;
    end else if (ena) begin
      r_out_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_vld) begin
            if (w_div_go) begin
              r_state  <= ST_DIV;
              r_in_rdy <= 1'b0;
              r_is_mod <= (opc == OP_MOD);
            end else begin
              r_res     <= w_res;
              r_o       <= w_o;
              r_cc      <= w_cc;
              r_out_vld <= 1'b1;
            end
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_res     <= r_is_mod ? w_rem : w_quo[W2-1:W];
            r_o       <= r_is_mod ? r_o   : w_quo[W-1:0];
            r_cc      <= 1'b1;
            r_out_vld <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_in_rdy <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_in_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign in_rdy  = r_in_rdy;
  assign out_vld = r_out_vld;
  assign res     = r_res;
  assign regO    = r_o;
  assign CC      = r_cc;

endmodule
